bcd_display_scanner: RTL and testbench

- Output-side counterpart of the keypad-to-BCD entry path in the timer control block.
- Takes a four-digit BCD time value (MM:SS), captures it on a load strobe and decodes each digit to seven-segment patterns.
- Time-multiplexes the four digits onto a shared active-low segment bus, with per-digit active-low anode enables.
- Supports leading-zero blanking, a colon indicator, and whole-display blinking for the paused/finished state.

---
 rtl/bcd_display_scanner.sv | 169 ++++++++++++++++
 tb/tb_bcd_display_scanner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module  : bcd_display_scanner
// Purpose : Captures a four-digit BCD MM:SS value and drives a time-multiplexed,
//           common-bus seven-segment display. It supports leading-zero
//           blanking of the minutes digits, a colon indicator during the
//           minutes-units slot, and whole-display blinking.
// Ports   : clk         - system clock, rising edge
//           resetn      - asynchronous active-low reset
//           load        - capture strobe for digits_in (into pending register)
//           digits_in   - BCD [15:12] min tens .. [3:0] sec units
//           blank_lz    - blank leading zeros of the minutes digits
//           blink_en    - blink the whole display
//           seg_n       - active-low segments, [6]=a .. [0]=g
//           dp_n        - active-low colon / decimal point
//           an_n        - active-low digit enables, [0]=sec units .. [3]=min tens
//           frame_done  - one-cycle pulse after each complete 4-digit frame
// Revision: 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]       SEG_BLANK  = 7'h7F;

    // Blink phase state machine
    localparam logic [0:0] PH_VISIBLE = 1'b0;
    localparam logic [0:0] PH_HIDDEN  = 1'b1;

    logic [15:0]      pending_q, pending_d;
    logic [15:0]      active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [0:0]       phase_q, phase_d;
    logic             blink_en_prev_q, blink_en_prev_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic             dp_n_q, dp_n_d;
    logic [3:0]       an_n_q, an_n_d;
    logic             frame_done_q, frame_done_d;

    logic             cnt_wrap;
    logic             frame_wrap;
    logic             hidden;
    logic             lz_blank;
    logic [3:0]       cur_digit;

    // Active-low decode, bit order a..g from MSB to LSB; non-decimal codes blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0000001;
            4'd1:    p = 7'b1001111;
            4'd2:    p = 7'b0010010;
            4'd3:    p = 7'b0000110;
            4'd4:    p = 7'b1001100;
            4'd5:    p = 7'b0100100;
            4'd6:    p = 7'b0100000;
            4'd7:    p = 7'b0001111;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0000100;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    always_comb begin
        cnt_wrap   = (cnt_q == CNT_LAST);
        frame_wrap = cnt_wrap && (idx_q == 2'd3);

        // Pending captures every load; active only updates at the frame
        // boundary and takes the pre-edge pending value, so a load landing on
        // the boundary waits for the following frame.
        pending_d = load ? digits_in : pending_q;
        active_d  = frame_wrap ? pending_q : active_q;

        cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = cnt_wrap ? idx_q + 2'd1 : idx_q;

        // Blink: disabled or just enabled -> restart from the visible phase.
        blink_en_prev_d = blink_en;
        blink_cnt_d     = blink_cnt_q;
        phase_d         = phase_q;
        if (!blink_en || !blink_en_prev_q) begin
            blink_cnt_d = '0;
            phase_d     = PH_VISIBLE;
        end else if (frame_wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end

        // Live blink_en gates the hidden phase so dropping it shows the
        // display on the very next output cycle.
        hidden = blink_en && (phase_q == PH_HIDDEN);

        cur_digit = active_q[{idx_q, 2'b00} +: 4];
        lz_blank  = blank_lz &&
                    (((idx_q == 2'd3) && (active_q[15:12] == 4'd0)) ||
                     ((idx_q == 2'd2) && (active_q[15:8]  == 8'd0)));

        seg_n_d = lz_blank ? SEG_BLANK : seg_decode(cur_digit);

        // cnt==0 is dead time between digits to avoid ghosting.
        if (hidden || (cnt_q == '0)) begin
            an_n_d = 4'b1111;
        end else begin
            an_n_d = ~(4'b0001 << idx_q);
        end

        dp_n_d       = !((idx_q == 2'd2) && !hidden);
        frame_done_d = frame_wrap;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q       <= '0;
            active_q        <= '0;
            cnt_q           <= '0;
            idx_q           <= '0;
            blink_cnt_q     <= '0;
            phase_q         <= PH_VISIBLE;
            blink_en_prev_q <= 1'b0;
            seg_n_q         <= SEG_BLANK;
            dp_n_q          <= 1'b1;
            an_n_q          <= 4'b1111;
            frame_done_q    <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            active_q        <= active_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            blink_cnt_q     <= blink_cnt_d;
            phase_q         <= phase_d;
            blink_en_prev_q <= blink_en_prev_d;
            seg_n_q         <= seg_n_d;
            dp_n_q          <= dp_n_d;
            an_n_q          <= an_n_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_display_scanner
// Purpose : Self-checking bench for bcd_display_scanner. Every output cycle is
//           compared against a timeline model: the display state is derived
//           from the number of clock edges since reset, the list of loads and
//           the edge at which blinking was enabled.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    localparam int D  = 4;      // REFRESH_DIV
    localparam int BF = 2;      // BLINK_FRAMES
    localparam int FR = 4 * D;  // cycles per frame

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        load      = 1'b0;
    logic [15:0] digits_in = '0;
    logic        blank_lz  = 1'b0;
    logic        blink_en  = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    bcd_display_scanner #(
        .REFRESH_DIV  (D),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .digits_in  (digits_in),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Timeline model state
    int          k          = 0;   // clock edges since reset release
    int          e_rise     = -1;  // edge at which blink_en was first seen high
    logic        blink_prev = 1'b0;
    int          load_edge[$];
    logic [15:0] load_val[$];

    // Lit segments of each decimal digit
    string lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] pattern(input logic [3:0] d);
        logic [6:0] p;
        string      s;
        p = 7'h7F;
        if (d <= 4'd9) begin
            s = lit[d];
            for (int i = 0; i < s.len(); i++) begin
                p[6 - (int'(s[i]) - 97)] = 1'b0;
            end
        end
        return p;
    endfunction

    // Value shown during frame f: last load strictly before the edge that
    // opens frame f.
    function automatic logic [15:0] active_for(input int f);
        logic [15:0] v;
        v = '0;
        foreach (load_edge[i]) begin
            if (load_edge[i] < FR * f) v = load_val[i];
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        k          = 0;
        e_rise     = -1;
        blink_prev = 1'b0;
        load_edge.delete();
        load_val.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_seg", 16'(seg_n), 16'h7F);
        chk("rst_an",  16'(an_n), 16'hF);
        chk("rst_dp",  16'(dp_n), 16'h1);
        chk("rst_fd",  16'(frame_done), 16'h0);
    endtask

    // One clock edge: update the model with the sampled inputs, then check.
    task automatic step();
        int          s, cnt, idx, f, w;
        logic        ph, hidden, blank;
        logic [15:0] act;
        logic [6:0]  eseg;
        logic [3:0]  ean;
        logic        edp, efd;
        @(posedge clk);
        if (!resetn) begin
            #1;
            chk_reset_vals();
        end else begin
            k++;
            if (load) begin
                load_edge.push_back(k);
                load_val.push_back(digits_in);
            end
            if (blink_en && !blink_prev) e_rise = k;
            blink_prev = blink_en;

            s   = k - 1;
            cnt = s % D;
            idx = (s / D) % 4;
            f   = s / FR;
            act = active_for(f);
            ph  = 1'b0;
            if (e_rise >= 0 && e_rise < k) begin
                w  = f - e_rise / FR;
                ph = ((w / BF) % 2) == 1;
            end
            hidden = blink_en && ph;
            blank  = blank_lz && ((idx == 3 && act[15:12] == 0) ||
                                  (idx == 2 && act[15:8] == 0));
            eseg   = blank ? 7'h7F : pattern(act[idx*4 +: 4]);
            ean    = 4'hF;
            if (!hidden && cnt != 0) ean[idx] = 1'b0;
            edp    = !(idx == 2 && !hidden);
            efd    = (k % FR) == 0;
            #1;
            chk("seg", 16'(seg_n), 16'(eseg));
            chk("an",  16'(an_n), 16'(ean));
            chk("dp",  16'(dp_n), 16'(edp));
            chk("fd",  16'(frame_done), 16'(efd));
        end
    endtask

    // Advance until the next edge samples slot idx at prescaler value c.
    task automatic run_until(input int idx, input int c);
        int guard;
        guard = 0;
        while ((k % FR) != (idx * D + c) && guard < 2 * FR) begin
            step();
            guard++;
        end
        if ((k % FR) != (idx * D + c)) begin
            n_total++;
            n_fail++;
            $error("FAIL run_until: slot %0d not reached, state %0d", idx, k % FR);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset held, then release; first anode appears at cnt=1.
        model_reset();
        repeat (3) step();
        resetn = 1'b1;

        // 2. Load 1259, plain decode, frame_done cadence.
        digits_in = 16'h1259;
        load      = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * FR) step();

        // 3. Anti-tearing: two loads in one frame, last wins at next frame.
        run_until(1, 1);
        digits_in = 16'h0000;
        load      = 1'b1;
        step();
        load = 1'b0;
        run_until(2, 1);
        digits_in = 16'h0347;
        load      = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * FR) step();

        // 4. Leading-zero blanking.
        blank_lz = 1'b1;
        repeat (FR) step();
        digits_in = 16'h0007;
        load      = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * FR) step();

        // Load on the exact frame-boundary edge goes to pending only.
        run_until(3, D - 1);
        digits_in = 16'h4321;
        load      = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * FR) step();

        // 5. Blink enabled at a frame boundary, then dropped mid-hidden frame.
        blank_lz  = 1'b0;
        digits_in = 16'h1259;
        load      = 1'b1;
        step();
        load = 1'b0;
        run_until(3, D - 1);
        blink_en = 1'b1;
        repeat (6 * FR) step();
        repeat (FR / 2) step();
        blink_en = 1'b0;
        repeat (FR) step();

        // Randomized traffic.
        repeat (400) begin
            load      = ($urandom_range(0, 7) == 0);
            digits_in = 16'($urandom);
            blank_lz  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
            step();
        end
        load     = 1'b0;
        blink_en = 1'b0;
        blank_lz = 1'b0;
        repeat (FR) step();

        // 6. Invalid codes, then asynchronous reset in slot 2.
        digits_in = 16'hA0F5;
        load      = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * FR) step();
        run_until(2, 1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk_reset_vals();
        repeat (2) step();
        resetn = 1'b1;
        repeat (2 * FR) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
